booth_seq_multiplier: RTL and testbench
=======================================

# booth_seq_multiplier

Sequential radix-2 Booth multiplier: signed 8-bit × signed 8-bit → signed 16-bit product in 8 iteration cycles. It sits directly downstream of the 16-bit conditional-invert stage and consumes its output. Subtraction is performed as the inverted 16-bit operand plus carry-in 1, with the inverter enable also serving as the adder carry-in. Start/done handshake toward the sequencing controller.

## Interface
- Parameters: none. Widths are fixed at 8 × 8 → 16; constants are in the shared package.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when not busy
- multiplicand  in  8  signed two's-complement operand M; captured with start
- multiplier  in  8  signed two's-complement operand Q; captured with start
- busy  out  1  high while iterating
- done  out  1  one-cycle pulse; product valid from this cycle onward
- product  out  16  signed result; held until the next accepted start or rst

## Operation
- Datapath registers:
  - acc[15:0]: partial product.
  - mreg[15:0]: M sign-extended to 16 bits.
  - qreg[7:0]
  - qprev: Booth extra bit.
  - cnt[3:0]
- FSM states: IDLE, CALC, DONE.
  - IDLE: if start, then acc←0, mreg←sext(M), qreg←Q, qprev←0, cnt←0, go to CALC.
  - CALC: each cycle examines the pair {qreg[0], qprev}:
    - 01: acc ← acc + mreg.
    - 10: acc ← acc + ~mreg + 1. The inverter enable = 1, and the same bit drives the adder carry-in.
    - 00 / 11: acc unchanged.
    - Then mreg ← mreg << 1, qprev ← qreg[0], qreg ← qreg >> 1, cnt ← cnt + 1.
    - After the iteration with cnt == 7, go to DONE.
  - DONE: done = 1. If start, reload as in IDLE and go to CALC; otherwise go to IDLE.
- Arithmetic is modulo 2^16, and the 16-bit result is exact for every 8×8 signed pair. The range is −16256 … +16384.
- The inverter enable is 1 only on the 10 pair. It is 0 in IDLE and DONE, so acc is never disturbed outside CALC.
- product = acc, driven combinationally from the register.
- start while busy: ignored. No queuing and no error.
- Operand inputs are don't-care except in the cycle where start is accepted.

## Timing
- Reset values: state = IDLE, busy = 0, done = 0, product = 0x0000. Internal registers are cleared to 0.
- rst has priority over every other input in every state. Asserted mid-CALC, the operation is aborted: no done pulse, and product = 0 on the next cycle.
- Latency:
  - start is sampled at edge k.
  - busy = 1 from after edge k until after edge k+8.
  - done = 1 for exactly the cycle between edges k+8 and k+9.
  - Total is 8 cycles from the accepting edge to done.
- Back-to-back: start held high in the DONE cycle is accepted at edge k+9. The next done then arrives at edge k+17, giving a throughput of 1 result per 9 cycles.
- busy and done are never high together.

## Structure
- Shared package:
  - MUL_IN_W = 8, MUL_P_W = 16, MUL_ITER = 8.
  - State enum {IDLE, CALC, DONE}.
  - Booth pair constants.
- Sub-module `add_sub16`: 16-bit ripple adder taking A, B and sub.
  - It instantiates the team's 16-bit conditional inverter on B, with enable = sub.
  - sub is also the adder carry-in.
  - It is purely combinational; the FSM, shift registers and counter stay in the top module.

## Test plan
- 3 × 5: start for one cycle → done pulse exactly 8 cycles after the accepting edge, product = 0x000F; busy high for those 8 cycles.
- −3 × 5 (0xFD, 0x05) → product 0xFFF1. Then −128 × −128 (0x80, 0x80) → 0x4000. Then 127 × −128 (0x7F, 0x80) → 0xC080.
- 0 × −1 and −1 × −1 → 0x0000 and 0x0001. Alternating multiplier patterns 0x55 and 0xAA against M = 0x01 → 0x0055 and 0xFFAA.
- start re-pulsed with different operands at CALC cycles 2 and 5 → ignored; the first result is still 3 × 5 = 0x000F at the original cycle.
- rst asserted at CALC cycle 4 → no done, product = 0x0000 next cycle, state IDLE. Then start 7 × 7 → done 8 cycles later with 0x0031.
- start held high continuously: operands 2 × 3 then 4 × 4 → done pulses 9 cycles apart, product 0x0006 then 0x0010. The product is held between the pulses.

Source files
------------

// File: rtl/booth_seq_multiplier_pkg.sv
// rtl/booth_seq_multiplier_pkg.sv - shared widths, FSM states and Booth pair codes
package booth_seq_multiplier_pkg;
  localparam int MUL_IN_W = 8;
  localparam int MUL_P_W  = 16;
  localparam int MUL_ITER = 8;

  localparam logic [3:0] LAST_CNT = 4'(MUL_ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth pair {q[0], qprev}: 01 adds M, 10 subtracts M, 00/11 leave acc alone
  localparam logic [1:0] PAIR_ADD = 2'b01;
  localparam logic [1:0] PAIR_SUB = 2'b10;
endpackage

// File: rtl/add_sub16.sv
// rtl/add_sub16.sv - 16-bit ripple add/subtract; sub inverts b and doubles as the carry-in
module add_sub16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] sum
);
  logic [15:0] b_inv;

  cond_inv16 u_inv (
    .data   (b),
    .en     (sub),
    .result (b_inv)
  );

  always_comb begin
    logic carry;
    carry = sub;
    sum   = '0;
    for (int i = 0; i < 16; i++) begin
      sum[i] = a[i] ^ b_inv[i] ^ carry;
      carry  = (a[i] & b_inv[i]) | (carry & (a[i] ^ b_inv[i]));
    end
  end
endmodule

// File: rtl/cond_inv16.sv
// rtl/cond_inv16.sv - 16-bit conditional inverter, passes data through unless en is set
module cond_inv16 (
  input  logic [15:0] data,
  input  logic        en,
  output logic [15:0] result
);
  assign result = data ^ {16{en}};
endmodule

// File: rtl/booth_seq_multiplier.sv
// rtl/booth_seq_multiplier.sv - sequential radix-2 Booth multiplier, 8x8 signed -> 16 in 8 iterations
module booth_seq_multiplier
  import booth_seq_multiplier_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);
  state_t      state;
  state_t      state_next;
  logic [15:0] acc;
  logic [15:0] mreg;
  logic [7:0]  qreg;
  logic        qprev;
  logic [3:0]  cnt;
  logic        load;
  logic        sub_en;
  logic [1:0]  pair;
  logic [15:0] sum;

  assign pair = {qreg[0], qprev};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == LAST_CNT) state_next = DONE;
      DONE:    state_next = start ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // sub_en is forced low outside CALC so the adder never drives acc there
  always_comb begin
    busy   = (state == CALC);
    done   = (state == DONE);
    load   = start && (state != CALC);
    sub_en = (state == CALC) && (pair == PAIR_SUB);
  end

  add_sub16 u_add_sub (
    .a   (acc),
    .b   (mreg),
    .sub (sub_en),
    .sum (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      mreg  <= '0;
      qreg  <= '0;
      qprev <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= '0;
      mreg  <= {{(MUL_P_W - MUL_IN_W){multiplicand[7]}}, multiplicand};
      qreg  <= multiplier;
      qprev <= 1'b0;
      cnt   <= '0;
    end else if (state == CALC) begin
      if (pair == PAIR_ADD || pair == PAIR_SUB) acc <= sum;
      mreg  <= mreg << 1;
      qprev <= qreg[0];
      qreg  <= qreg >> 1;
      cnt   <= cnt + 4'd1;
    end
  end

  assign product = acc;
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb/tb_booth_seq_multiplier.sv - self-checking bench for booth_seq_multiplier
module tb_booth_seq_multiplier;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  mc;
  logic [7:0]  mp;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_checks = 0;
  int n_pass   = 0;

  booth_seq_multiplier dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (mc),
    .multiplier   (mp),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [15:0] ref_mul(input logic [7:0] m, input logic [7:0] q);
    int a;
    int b;
    int p;
    a = $signed(m);
    b = $signed(q);
    p = a * b;
    return p[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Counts negedges after the accepting edge until done, optionally re-pulsing start mid-CALC
  task automatic wait_done(input int poke_a, input int poke_b, output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 20) begin
      if (!busy) busy_ok = 1'b0;
      if (lat == poke_a || lat == poke_b) begin
        start = 1'b1;
        mc = 8'h7F;
        mp = 8'h81;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic do_op(input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp,
                       input string name, input int poke_a, input int poke_b);
    int lat;
    bit busy_ok;
    logic [15:0] held;
    @(negedge clk);
    start = 1'b1;
    mc = m;
    mp = q;
    @(negedge clk);
    start = 1'b0;
    mc = 8'($urandom);
    mp = 8'($urandom);
    wait_done(poke_a, poke_b, lat, busy_ok);
    check({name, " latency"}, lat, 8);
    check({name, " busy during calc"}, busy_ok, 1);
    check({name, " product"}, product, exp);
    check({name, " busy with done"}, busy, 0);
    held = product;
    @(negedge clk);
    check({name, " done one cycle"}, done, 0);
    check({name, " product held"}, product, held);
  endtask

  initial begin
    int d[$];
    logic [15:0] p[$];
    bit saw_done;

    vecs[0] = '{8'h03, 8'h05, 16'h000F};
    vecs[1] = '{8'hFD, 8'h05, 16'hFFF1};
    vecs[2] = '{8'h80, 8'h80, 16'h4000};
    vecs[3] = '{8'h7F, 8'h80, 16'hC080};
    vecs[4] = '{8'h00, 8'hFF, 16'h0000};
    vecs[5] = '{8'hFF, 8'hFF, 16'h0001};
    vecs[6] = '{8'h01, 8'h55, 16'h0055};
    vecs[7] = '{8'h01, 8'hAA, 16'hFFAA};

    rst = 1'b1;
    start = 1'b0;
    mc = 8'h00;
    mp = 8'h00;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset product", product, 16'h0000);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].m, vecs[i].q, vecs[i].exp, $sformatf("vec%0d", i), -1, -1);

    do_op(8'h03, 8'h05, 16'h000F, "repulse", 2, 5);

    // Abort mid-CALC with rst
    @(negedge clk);
    start = 1'b1;
    mc = 8'h03;
    mp = 8'h05;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort product", product, 16'h0000);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("abort no done", saw_done, 0);
    do_op(8'h07, 8'h07, 16'h0031, "after abort", -1, -1);

    // start held high: second operation accepted in the DONE cycle
    @(negedge clk);
    start = 1'b1;
    mc = 8'h02;
    mp = 8'h03;
    @(negedge clk);
    mc = 8'h04;
    mp = 8'h04;
    for (int i = 0; i < 30 && d.size() < 2; i++) begin
      if (done) begin
        d.push_back(i);
        p.push_back(product);
        if (busy) p.push_back(16'hDEAD);
      end
      if (d.size() == 2) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b pulse count", d.size(), 2);
    while (d.size() < 2) begin
      d.push_back(-1);
      p.push_back(16'hxxxx);
    end
    check("b2b first done", d[0], 8);
    check("b2b second done", d[1], 17);
    check("b2b first product", p[0], 16'h0006);
    check("b2b second product", p[1], 16'h0010);
    @(negedge clk);
    check("b2b returns idle", {busy, done}, 2'b00);

    for (int i = 0; i < 24; i++) begin
      logic [7:0] m;
      logic [7:0] q;
      m = 8'($urandom);
      q = 8'($urandom);
      do_op(m, q, ref_mul(m, q), $sformatf("rand%0d %0h*%0h", i, m, q), -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
